// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix (emulator and scanner key map).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Key code layout: upper two bits select the row, lower two the column.
    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Active-low one-hot row drive pattern for a given row index.
    function automatic logic [3:0] row_pattern(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

    // Active-low one-hot column sense pattern for a given column index.
    function automatic logic [3:0] col_pattern(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    // Split a raw 4-bit key code into its row/column fields.
    function automatic key_t split_key(input logic [3:0] code);
        key_t k;
        k.row = code[3:2];
        k.col = code[1:0];
        return k;
    endfunction

endpackage

// File: rtl/keypad_matrix_drive.sv
// Combinational column answer for the pressed key: column pulled low only when its row is driven.
// Latency: zero (purely combinational from fila).
// Backpressure: none; idle columns read 4'b1111.
module keypad_matrix_drive
    import keypad_pkg::*;
(
    input  logic       pressing,
    input  logic [1:0] row,
    input  logic [1:0] col,
    input  logic [3:0] fila,
    output logic [3:0] columna
);

    // Exact-match on the row pattern rejects all-high and multi-row-low drives.
    always_comb begin
        columna = COL_IDLE;
        if (pressing && (fila == row_pattern(row))) begin
            columna = col_pattern(col);
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad responder: accepts one key command, holds it HOLD_CYCLES, forces release RELEASE_CYCLES, pulses done.
// Latency: done arrives 1+HOLD_CYCLES+RELEASE_CYCLES cycles after accept; columna is zero-latency from fila.
// Backpressure: cmd_ready low from accept until the done cycle; commands while not ready are ignored.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 64,
    parameter int RELEASE_CYCLES = 32,
    parameter int MIN_SCANS      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_key,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    output logic       busy,
    output logic       done,
    output logic       scan_err
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam int SW = $clog2(MIN_SCANS + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(MIN_SCANS);

    state_t          state;
    key_t            key_q;
    logic [HW-1:0]   hold_cnt;
    logic [RW-1:0]   rel_cnt;
    logic [SW-1:0]   scan_cnt;
    logic [SW-1:0]   scan_cnt_next;
    logic [3:0]      fila_q;
    logic [3:0]      target_row;
    logic            scan_hit;
    logic            scan_err_n;

    // A scan counts only on the first cycle the target row is driven (rising activation).
    always_comb begin
        target_row    = row_pattern(key_q.row);
        scan_hit      = (state == PRESS) && (fila == target_row) && (fila_q != target_row);
        scan_cnt_next = scan_cnt;
        if (scan_hit && (scan_cnt != SCAN_MAX)) begin
            scan_cnt_next = scan_cnt + SW'(1);
        end
    end

    // Previous-cycle row drive, used for activation edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fila_q <= ROW_IDLE;
        end else begin
            fila_q <= fila;
        end
    end

    // Command FSM with counters and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            key_q      <= '0;
            hold_cnt   <= '0;
            rel_cnt    <= '0;
            scan_cnt   <= '0;
            scan_err_n <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        key_q     <= split_key(cmd_key);
                        hold_cnt  <= '0;
                        scan_cnt  <= '0;
                        scan_err  <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= PRESS;
                    end
                end
                PRESS: begin
                    scan_cnt <= scan_cnt_next;
                    if (hold_cnt == HOLD_LAST) begin
                        rel_cnt    <= '0;
                        scan_err_n <= (scan_cnt_next < SCAN_MAX);
                        state      <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        done      <= 1'b1;
                        scan_err  <= scan_err_n;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        rel_cnt <= rel_cnt + RW'(1);
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    keypad_matrix_drive u_matrix_drive (
        .pressing (state == PRESS),
        .row      (key_q.row),
        .col      (key_q.col),
        .fila     (fila),
        .columna  (columna)
    );

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: cycle-numbered reference model plus done-pulse monitor.
// Latency: model expects done 1+HOLD+REL cycles after each accept.
// Backpressure: model derives readiness from its own command windows.
module tb_keypad_emulator;

    localparam int HOLD = 64;
    localparam int REL  = 32;
    localparam int MINS = 2;
    localparam logic [3:0] ONE = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [3:0] fila;
    logic [3:0] columna;
    logic       busy;
    logic       done;
    logic       scan_err;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES    (HOLD),
        .RELEASE_CYCLES (REL),
        .MIN_SCANS      (MINS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .fila      (fila),
        .columna   (columna),
        .busy      (busy),
        .done      (done),
        .scan_err  (scan_err)
    );

    typedef struct {
        int   dcyc;
        logic err;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         acc      = -100000;
    int         scans    = 0;
    int         accepts  = 0;
    int         fmode    = 1;
    logic [3:0] key_m    = 4'h0;
    logic [3:0] prev_fila = 4'hF;
    logic       exp_err_out = 1'b0;
    logic       cur_err  = 1'b0;
    logic       pend_acc = 1'b0;
    logic [3:0] pend_key = 4'h0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    // Row-drive generator: 0 scan every 4 cycles, 1 all-high, 2 two rows low,
    // 3 sparse random, 4 dense random.
    function automatic logic [3:0] gen_fila(input int mode, input int c);
        int r;
        case (mode)
            0: return ~(ONE << ((c / 4) % 4));
            1: return 4'hF;
            2: return 4'b1001;
            3: begin
                r = $urandom_range(0, 63);
                if (r < 4) return ~(ONE << r);
                if (r == 4) return 4'($urandom_range(0, 15));
                return 4'hF;
            end
            default: begin
                r = $urandom_range(0, 7);
                if (r < 4) return ~(ONE << r);
                if (r < 6) return 4'hF;
                return 4'($urandom_range(0, 15));
            end
        endcase
    endfunction

    function automatic logic model_in_press(input int c);
        return (c > acc) && (c <= acc + HOLD);
    endfunction

    // One clock: apply inputs after the edge, advance the model, compare at the falling edge.
    task automatic tick(input logic v, input logic [3:0] k);
        logic [3:0] tgt;
        logic [3:0] exp_col;
        logic       in_press;
        logic       busy_m;
        logic       done_m;
        @(posedge clk);
        cyc++;
        #1;
        if (pend_acc) begin
            acc   = cyc - 1;
            key_m = pend_key;
            scans = 0;
        end
        pend_acc  = 1'b0;
        fila      = gen_fila(fmode, cyc);
        cmd_valid = v;
        cmd_key   = k;

        in_press = model_in_press(cyc);
        busy_m   = (cyc > acc) && (cyc <= acc + HOLD + REL);
        done_m   = (cyc == acc + HOLD + REL + 1);
        tgt      = ~(ONE << key_m[3:2]);
        if (in_press && fila == tgt && prev_fila != tgt && scans < MINS) scans++;
        exp_col  = (in_press && fila == tgt) ? ~(ONE << key_m[1:0]) : 4'hF;
        if (cyc == acc + 1) exp_err_out = 1'b0;
        if (cyc == acc + HOLD) begin
            cur_err = (scans < MINS);
            sb.push_back('{dcyc: acc + HOLD + REL + 1, err: cur_err});
        end
        if (done_m) exp_err_out = cur_err;
        if (!busy_m && v && !rst) begin
            pend_acc = 1'b1;
            pend_key = k;
            accepts++;
        end
        prev_fila = fila;

        @(negedge clk);
        check4("columna",   columna,             exp_col);
        check4("cmd_ready", {3'b000, cmd_ready}, {3'b000, !busy_m});
        check4("busy",      {3'b000, busy},      {3'b000, busy_m});
        check4("done",      {3'b000, done},      {3'b000, done_m});
        check4("scan_err",  {3'b000, scan_err},  {3'b000, exp_err_out});
    endtask

    task automatic run_cmd(input logic [3:0] k);
        tick(1'b1, k);
        repeat (HOLD + REL + 3) tick(1'b0, 4'($urandom_range(0, 15)));
    endtask

    // Done-pulse monitor: each pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected cyc=%0d actual=pulse required=none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (e.dcyc != cyc || e.err !== scan_err) begin
                    failures++;
                    $display("FAIL done_pulse actual cyc=%0d err=%b required cyc=%0d err=%b",
                             cyc, scan_err, e.dcyc, e.err);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        int start;
        bit found;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = 4'h0;
        fila      = 4'hF;
        #2;
        check4("reset_columna",   columna,             4'hF);
        check4("reset_cmd_ready", {3'b000, cmd_ready}, 4'h1);
        check4("reset_busy",      {3'b000, busy},      4'h0);
        check4("reset_done",      {3'b000, done},      4'h0);
        check4("reset_scan_err",  {3'b000, scan_err},  4'h0);
        repeat (3) tick(1'b0, 4'h0);
        rst = 1'b0;
        repeat (3) tick(1'b0, 4'h0);

        // Single press, row1/col2 under a regular scan.
        fmode = 0;
        run_cmd(4'b0110);

        // Starved scan: rows never driven.
        fmode = 1;
        run_cmd(4'b0000);

        // Back-to-back with cmd_valid held high: key F then key 0.
        fmode = 0;
        start = accepts;
        for (int i = 0; i <= 2 * (HOLD + REL + 1); i++) begin
            tick(i <= HOLD + REL + 1, (accepts == start) ? 4'hF : 4'h0);
        end
        repeat (4) tick(1'b0, 4'h0);

        // Two rows low never answers nor counts as a scan.
        fmode = 2;
        run_cmd(4'b0100);

        // Command pulse during PRESS is ignored.
        fmode = 0;
        tick(1'b1, 4'b0110);
        repeat (10) tick(1'b0, 4'h0);
        tick(1'b1, 4'h3);
        repeat (HOLD + REL + 3) tick(1'b0, 4'h0);

        // Asynchronous reset while the key is answering on column 0.
        fmode = 0;
        tick(1'b1, 4'h0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1'b0, 4'h0);
            if (model_in_press(cyc) && fila == 4'b1110) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midpress_setup actual=no_row0_drive required=row0_drive");
        end
        #1;
        rst = 1'b1;
        #1;
        check4("async_rst_columna", columna,        4'hF);
        check4("async_rst_busy",    {3'b000, busy}, 4'h0);
        sb.delete();
        acc         = -100000;
        exp_err_out = 1'b0;
        pend_acc    = 1'b0;
        prev_fila   = 4'hF;
        fmode       = 1;
        repeat (3) tick(1'b0, 4'h0);
        rst = 1'b0;
        repeat (3) tick(1'b0, 4'h0);
        check4("post_rst_cmd_ready", {3'b000, cmd_ready}, 4'h1);

        // Randomised traffic with mixed row densities.
        repeat (12) begin
            fmode = $urandom_range(3, 4);
            repeat (120) tick($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
        end
        fmode = 1;
        repeat (HOLD + REL + 5) tick(1'b0, 4'h0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
